// File: rtl/row_store_pkg.sv
// Shared constants and scan FSM state type for the row cell bank.
package row_store_pkg;

  localparam int EMPTY_CELL      = 0;
  localparam int DEFAULT_WIN_LEN = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;

endpackage

// File: rtl/row_run_scanner.sv
// Longest-run tracker: counts consecutive points equal to the player code.
module row_run_scanner
  import row_store_pkg::*;
#(
  parameter int CELL_W  = 2,
  parameter int SEL_W   = 4,
  parameter int WIN_LEN = DEFAULT_WIN_LEN
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [CELL_W-1:0] point,
  input  logic [CELL_W-1:0] player,
  input  logic              step,
  input  logic              restart,
  output logic [SEL_W:0]    max_run,
  output logic              win
);

  localparam logic [SEL_W:0] WIN_T = (SEL_W + 1)'(WIN_LEN);
  localparam logic [SEL_W:0] ONE   = (SEL_W + 1)'(1);

  logic [SEL_W:0] run_len;
  logic [SEL_W:0] run_next;

  assign run_next = run_len + ONE;

  always_ff @(posedge clock) begin
    if (!reset || restart) begin
      run_len <= '0;
      max_run <= '0;
    end else if (step) begin
      if (point == player) begin
        run_len <= run_next;
        if (run_next > max_run) max_run <= run_next;
      end else begin
        run_len <= '0;
      end
    end
  end

  assign win = (max_run >= WIN_T);

endmodule

// File: rtl/row_cell_bank.sv
// One board row: guarded point storage, occupancy count and a serial run scan.
module row_cell_bank
  import row_store_pkg::*;
#(
  parameter int CELLS   = 16,
  parameter int CELL_W  = 2,
  parameter int WIN_LEN = DEFAULT_WIN_LEN,
  parameter int SEL_W   = $clog2(CELLS)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [SEL_W-1:0]        wr_sel,
  input  logic [CELL_W-1:0]       wr_data,
  input  logic                    clear,
  input  logic [SEL_W-1:0]        rd_sel,
  output logic [CELL_W-1:0]       rd_data,
  output logic [CELLS*CELL_W-1:0] row_out,
  output logic                    wr_ack,
  output logic                    wr_reject,
  output logic [SEL_W:0]          occ_count,
  input  logic                    scan_start,
  input  logic [CELL_W-1:0]       scan_player,
  output logic                    scan_busy,
  output logic                    scan_done,
  output logic [SEL_W:0]          max_run,
  output logic                    win
);

  localparam logic [SEL_W:0]    NUM_CELLS = (SEL_W + 1)'(CELLS);
  localparam logic [SEL_W-1:0]  LAST_IDX  = SEL_W'(CELLS - 1);
  localparam logic [CELL_W-1:0] EMPTY     = CELL_W'(EMPTY_CELL);
  localparam logic [SEL_W:0]    ONE       = (SEL_W + 1)'(1);

  logic [CELL_W-1:0] cells [CELLS];
  scan_state_t       state;
  logic [SEL_W-1:0]  scan_idx;
  logic [CELL_W-1:0] player_q;

  logic              wr_in_range;
  logic              rd_in_range;
  logic [CELL_W-1:0] target;
  logic              wr_accept;
  logic              scan_go;

  assign wr_in_range = ({1'b0, wr_sel} < NUM_CELLS);
  assign rd_in_range = ({1'b0, rd_sel} < NUM_CELLS);

  always_comb begin
    target = EMPTY;
    if (wr_in_range) target = cells[wr_sel];
  end

  // A nonzero value may only land on an empty point; erasing is always allowed.
  assign wr_accept = wr_en && !clear && (state != SCAN) && wr_in_range &&
                     ((wr_data == EMPTY) || (target == EMPTY));

  assign scan_go = !clear && (state == IDLE) && scan_start;

  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      for (int i = 0; i < CELLS; i++) cells[i] <= EMPTY;
      occ_count <= '0;
    end else if (wr_accept) begin
      cells[wr_sel] <= wr_data;
      if ((wr_data != EMPTY) && (target == EMPTY))
        occ_count <= occ_count + ONE;
      else if ((wr_data == EMPTY) && (target != EMPTY))
        occ_count <= occ_count - ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_data   <= '0;
      wr_ack    <= 1'b0;
      wr_reject <= 1'b0;
    end else begin
      rd_data   <= rd_in_range ? cells[rd_sel] : EMPTY;
      wr_ack    <= wr_accept;
      wr_reject <= wr_en && !wr_accept;
    end
  end

  always_comb begin
    row_out = '0;
    for (int i = 0; i < CELLS; i++) row_out[i*CELL_W +: CELL_W] = cells[i];
  end

  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (scan_start) state <= SCAN;
        SCAN:    if (scan_idx == LAST_IDX) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (scan_go) begin
      scan_idx <= '0;
      player_q <= scan_player;
    end else if (state == SCAN) begin
      scan_idx <= scan_idx + 1'b1;
    end
  end

  assign scan_busy = (state == SCAN);
  assign scan_done = (state == DONE);

  row_run_scanner #(
    .CELL_W (CELL_W),
    .SEL_W  (SEL_W),
    .WIN_LEN(WIN_LEN)
  ) u_scanner (
    .clock  (clock),
    .reset  (reset),
    .point  (cells[scan_idx]),
    .player (player_q),
    .step   (scan_busy && !clear),
    .restart(clear || scan_go),
    .max_run(max_run),
    .win    (win)
  );

endmodule

// File: tb/tb_row_cell_bank.sv
// Directed bench for row_cell_bank: default row plus a CELLS=15, CELL_W=3 instance.
module tb_row_cell_bank;

  logic        clock = 1'b0;
  logic        reset = 1'b0;

  logic        wr_en = 1'b0;
  logic [3:0]  wr_sel = '0;
  logic [1:0]  wr_data = '0;
  logic        clear = 1'b0;
  logic [3:0]  rd_sel = '0;
  logic [1:0]  rd_data;
  logic [31:0] row_out;
  logic        wr_ack, wr_reject;
  logic [4:0]  occ_count;
  logic        scan_start = 1'b0;
  logic [1:0]  scan_player = '0;
  logic        scan_busy, scan_done;
  logic [4:0]  max_run;
  logic        win;

  logic        b_wr_en = 1'b0;
  logic [3:0]  b_wr_sel = '0;
  logic [2:0]  b_wr_data = '0;
  logic        b_clear = 1'b0;
  logic [3:0]  b_rd_sel = '0;
  logic [2:0]  b_rd_data;
  logic [44:0] b_row_out;
  logic        b_wr_ack, b_wr_reject;
  logic [4:0]  b_occ_count;
  logic        b_scan_start = 1'b0;
  logic [2:0]  b_scan_player = '0;
  logic        b_scan_busy, b_scan_done;
  logic [4:0]  b_max_run;
  logic        b_win;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clock = ~clock;

  row_cell_bank dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .clear(clear), .rd_sel(rd_sel), .rd_data(rd_data), .row_out(row_out),
    .wr_ack(wr_ack), .wr_reject(wr_reject), .occ_count(occ_count),
    .scan_start(scan_start), .scan_player(scan_player), .scan_busy(scan_busy),
    .scan_done(scan_done), .max_run(max_run), .win(win)
  );

  row_cell_bank #(.CELLS(15), .CELL_W(3)) dut_b (
    .clock(clock), .reset(reset), .wr_en(b_wr_en), .wr_sel(b_wr_sel), .wr_data(b_wr_data),
    .clear(b_clear), .rd_sel(b_rd_sel), .rd_data(b_rd_data), .row_out(b_row_out),
    .wr_ack(b_wr_ack), .wr_reject(b_wr_reject), .occ_count(b_occ_count),
    .scan_start(b_scan_start), .scan_player(b_scan_player), .scan_busy(b_scan_busy),
    .scan_done(b_scan_done), .max_run(b_max_run), .win(b_win)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_write(input logic [3:0] sel, input logic [1:0] data);
    wr_en = 1'b1; wr_sel = sel; wr_data = data;
    step();
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    step(); step();
    total_cnt++; if (occ_count !== 5'd0) $display("FAIL reset_occ got %0d want 0", occ_count); else pass_cnt++;
    total_cnt++; if (row_out !== 32'd0) $display("FAIL reset_row got %h want 0", row_out); else pass_cnt++;
    total_cnt++; if ({rd_data, wr_ack, wr_reject} !== 4'b0) $display("FAIL reset_rd_ack got %b want 0000", {rd_data, wr_ack, wr_reject}); else pass_cnt++;
    total_cnt++; if ({scan_busy, scan_done, max_run, win} !== 8'd0) $display("FAIL reset_scan got %b want 0", {scan_busy, scan_done, max_run, win}); else pass_cnt++;
    reset = 1'b1;
    step();
  endtask

  task automatic test_write();
    do_write(4'd3, 2'b01);
    total_cnt++; if ({wr_ack, wr_reject} !== 2'b10) $display("FAIL write_ack got %b want 10", {wr_ack, wr_reject}); else pass_cnt++;
    total_cnt++; if (row_out[7:6] !== 2'b01) $display("FAIL write_row got %b want 01", row_out[7:6]); else pass_cnt++;
    total_cnt++; if (occ_count !== 5'd1) $display("FAIL write_occ got %0d want 1", occ_count); else pass_cnt++;
    rd_sel = 4'd3;
    step();
    total_cnt++; if (rd_data !== 2'b01) $display("FAIL write_rd got %b want 01", rd_data); else pass_cnt++;
    total_cnt++; if (wr_ack !== 1'b0) $display("FAIL ack_pulse got %b want 0", wr_ack); else pass_cnt++;
  endtask

  task automatic test_reject();
    do_write(4'd3, 2'b10);
    total_cnt++; if ({wr_ack, wr_reject} !== 2'b01) $display("FAIL overwrite_rej got %b want 01", {wr_ack, wr_reject}); else pass_cnt++;
    total_cnt++; if (row_out[7:6] !== 2'b01) $display("FAIL overwrite_keep got %b want 01", row_out[7:6]); else pass_cnt++;
    do_write(4'd3, 2'b00);
    total_cnt++; if ({wr_ack, wr_reject} !== 2'b10) $display("FAIL erase_ack got %b want 10", {wr_ack, wr_reject}); else pass_cnt++;
    total_cnt++; if ({occ_count, row_out} !== 37'd0) $display("FAIL erase_state got occ %0d row %h want 0", occ_count, row_out); else pass_cnt++;
    do_write(4'd3, 2'b00);
    total_cnt++; if ({wr_ack, occ_count} !== 6'b1_00000) $display("FAIL erase_empty got ack %b occ %0d want 1 0", wr_ack, occ_count); else pass_cnt++;
  endtask

  task automatic run_scan(input logic [1:0] player, output int busy_cycles);
    scan_player = player; scan_start = 1'b1;
    step();
    scan_start = 1'b0;
    busy_cycles = 0;
    while (scan_busy && busy_cycles < 40) begin
      busy_cycles++;
      step();
    end
  endtask

  task automatic test_scan();
    int busy;
    for (int i = 4; i <= 8; i++) do_write(4'(i), 2'b01);
    total_cnt++; if (row_out !== 32'h0001_5500) $display("FAIL fill_row got %h want 00015500", row_out); else pass_cnt++;
    total_cnt++; if (occ_count !== 5'd5) $display("FAIL fill_occ got %0d want 5", occ_count); else pass_cnt++;
    run_scan(2'b01, busy);
    total_cnt++; if (busy !== 16) $display("FAIL scan_len got %0d want 16", busy); else pass_cnt++;
    total_cnt++; if ({scan_done, max_run, win} !== {1'b1, 5'd5, 1'b1}) $display("FAIL scan_p1 got done %b max %0d win %b want 1 5 1", scan_done, max_run, win); else pass_cnt++;
    step();
    total_cnt++; if ({scan_done, max_run, win} !== {1'b0, 5'd5, 1'b1}) $display("FAIL scan_hold got done %b max %0d win %b want 0 5 1", scan_done, max_run, win); else pass_cnt++;
    run_scan(2'b10, busy);
    total_cnt++; if ({scan_done, max_run, win} !== {1'b1, 5'd0, 1'b0}) $display("FAIL scan_p2 got done %b max %0d win %b want 1 0 0", scan_done, max_run, win); else pass_cnt++;
    step();
    run_scan(2'b00, busy);
    total_cnt++; if ({scan_done, max_run, win} !== {1'b1, 5'd7, 1'b1}) $display("FAIL scan_empty got done %b max %0d win %b want 1 7 1", scan_done, max_run, win); else pass_cnt++;
    step();
  endtask

  task automatic test_write_in_scan();
    int busy;
    scan_player = 2'b01; scan_start = 1'b1;
    step();
    scan_start = 1'b0;
    do_write(4'd0, 2'b10);
    total_cnt++; if ({wr_ack, wr_reject} !== 2'b01) $display("FAIL scan_wr_rej got %b want 01", {wr_ack, wr_reject}); else pass_cnt++;
    total_cnt++; if (row_out !== 32'h0001_5500) $display("FAIL scan_wr_row got %h want 00015500", row_out); else pass_cnt++;
    busy = 0;
    while (!scan_done && busy < 40) begin busy++; step(); end
    total_cnt++; if (scan_done !== 1'b1) $display("FAIL scan_wr_done got %b want 1", scan_done); else pass_cnt++;
    step();
  endtask

  task automatic test_clear_write();
    clear = 1'b1;
    do_write(4'd0, 2'b01);
    clear = 1'b0;
    total_cnt++; if ({wr_ack, wr_reject} !== 2'b01) $display("FAIL clr_wr_rej got %b want 01", {wr_ack, wr_reject}); else pass_cnt++;
    total_cnt++; if ({occ_count, row_out} !== 37'd0) $display("FAIL clr_state got occ %0d row %h want 0", occ_count, row_out); else pass_cnt++;
  endtask

  task automatic test_clear_scan();
    int done_seen;
    for (int i = 4; i <= 8; i++) do_write(4'(i), 2'b01);
    scan_player = 2'b01; scan_start = 1'b1;
    step();
    scan_start = 1'b0;
    for (int i = 0; i < 7; i++) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    total_cnt++; if ({scan_busy, scan_done} !== 2'b00) $display("FAIL clr_scan_fsm got %b want 00", {scan_busy, scan_done}); else pass_cnt++;
    total_cnt++; if ({occ_count, max_run, win} !== 11'd0) $display("FAIL clr_scan_state got occ %0d max %0d win %b want 0 0 0", occ_count, max_run, win); else pass_cnt++;
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (scan_done || scan_busy) done_seen++;
      step();
    end
    total_cnt++; if (done_seen !== 0) $display("FAIL clr_scan_nodone got %0d want 0", done_seen); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_write(4'd4, 2'b11);
    rd_sel = 4'd4;
    scan_player = 2'b11; scan_start = 1'b1;
    step();
    scan_start = 1'b0;
    step(); step();
    total_cnt++; if ({scan_busy, rd_data} !== 3'b111) $display("FAIL pre_reset got %b want 111", {scan_busy, rd_data}); else pass_cnt++;
    reset = 1'b0;
    wr_en = 1'b1; wr_sel = 4'd9; wr_data = 2'b01;
    step();
    wr_en = 1'b0;
    total_cnt++; if ({occ_count, row_out} !== 37'd0) $display("FAIL mid_reset_store got occ %0d row %h want 0", occ_count, row_out); else pass_cnt++;
    total_cnt++; if ({rd_data, wr_ack, wr_reject, scan_busy, scan_done, max_run, win} !== 12'd0) $display("FAIL mid_reset_out got %b want 0", {rd_data, wr_ack, wr_reject, scan_busy, scan_done, max_run, win}); else pass_cnt++;
    reset = 1'b1;
    step();
    total_cnt++; if (scan_done !== 1'b0) $display("FAIL mid_reset_nodone got %b want 0", scan_done); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    do_write(4'd0, 2'b01);
    total_cnt++; if (wr_ack !== 1'b1) $display("FAIL b2b_ack0 got %b want 1", wr_ack); else pass_cnt++;
    do_write(4'd15, 2'b10);
    total_cnt++; if ({wr_ack, row_out[31:30], row_out[1:0], occ_count} !== {1'b1, 2'b10, 2'b01, 5'd2}) $display("FAIL b2b_ack15 got ack %b row %h occ %0d", wr_ack, row_out, occ_count); else pass_cnt++;
    rd_sel = 4'd15;
    step();
    total_cnt++; if (rd_data !== 2'b10) $display("FAIL b2b_rd15 got %b want 10", rd_data); else pass_cnt++;
  endtask

  task automatic test_param();
    int busy;
    b_wr_en = 1'b1; b_wr_sel = 4'd15; b_wr_data = 3'b101;
    step();
    total_cnt++; if ({b_wr_ack, b_wr_reject, b_occ_count} !== {2'b01, 5'd0}) $display("FAIL p_sel15 got ack %b rej %b occ %0d want 0 1 0", b_wr_ack, b_wr_reject, b_occ_count); else pass_cnt++;
    b_wr_sel = 4'd14;
    step();
    b_wr_en = 1'b0;
    total_cnt++; if ({b_wr_ack, b_row_out[44:42], b_occ_count} !== {1'b1, 3'b101, 5'd1}) $display("FAIL p_sel14 got ack %b val %b occ %0d want 1 101 1", b_wr_ack, b_row_out[44:42], b_occ_count); else pass_cnt++;
    b_rd_sel = 4'd14;
    step();
    total_cnt++; if (b_rd_data !== 3'b101) $display("FAIL p_rd14 got %b want 101", b_rd_data); else pass_cnt++;
    b_rd_sel = 4'd15;
    step();
    total_cnt++; if (b_rd_data !== 3'b000) $display("FAIL p_rd15 got %b want 000", b_rd_data); else pass_cnt++;
    b_scan_player = 3'b101; b_scan_start = 1'b1;
    step();
    b_scan_start = 1'b0;
    busy = 0;
    while (b_scan_busy && busy < 40) begin busy++; step(); end
    total_cnt++; if (busy !== 15) $display("FAIL p_scan_len got %0d want 15", busy); else pass_cnt++;
    total_cnt++; if ({b_scan_done, b_max_run, b_win} !== {1'b1, 5'd1, 1'b0}) $display("FAIL p_scan got done %b max %0d win %b want 1 1 0", b_scan_done, b_max_run, b_win); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_reject();
    test_scan();
    test_write_in_scan();
    test_clear_write();
    test_clear_scan();
    test_reset_mid();
    test_back_to_back();
    test_param();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
